// File: rtl/hazard3_regfile_ctrl_if.sv
// Signal bundle between the register file controller and its neighbours:
// the core pipeline, the debug module and the 1W2R register file macro.
interface hazard3_regfile_ctrl_if #(
    parameter int W_ADDR = 5,
    parameter int W_DATA = 32
);

    logic [W_ADDR-1:0] core_raddr1;
    logic [W_ADDR-1:0] core_raddr2;
    logic [W_ADDR-1:0] core_waddr;
    logic [W_DATA-1:0] core_wdata;
    logic              core_wen;
    logic              core_ready;

    logic              dbg_halted;
    logic              dbg_req;
    logic              dbg_write;
    logic [W_ADDR-1:0] dbg_addr;
    logic [W_DATA-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [W_DATA-1:0] dbg_rdata;

    logic [W_ADDR-1:0] rf_raddr1;
    logic [W_ADDR-1:0] rf_raddr2;
    logic [W_ADDR-1:0] rf_waddr;
    logic [W_DATA-1:0] rf_wdata;
    logic              rf_wen;
    logic [W_DATA-1:0] rf_rdata1;

    modport slave (
        input  core_raddr1, core_raddr2, core_waddr, core_wdata, core_wen,
        output core_ready,
        input  dbg_halted, dbg_req, dbg_write, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_wen,
        input  rf_rdata1
    );

    modport master (
        output core_raddr1, core_raddr2, core_waddr, core_wdata, core_wen,
        input  core_ready,
        output dbg_halted, dbg_req, dbg_write, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_wen,
        output rf_rdata1
    );

endinterface

// File: rtl/hazard3_regfile_ctrl.sv
// Register file front end: post-reset zero fill, core pass-through and
// debug abstract register access while the core is halted.
module hazard3_regfile_ctrl #(
    parameter int N_REGS         = 16,
    parameter int W_DATA         = 32,
    parameter int W_ADDR         = 5,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    hazard3_regfile_ctrl_if.slave bus
);

    localparam logic [1:0] ST_CLEAR   = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_ACK     = 2'd3;

    localparam logic [1:0] ST_RESET =
        (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    localparam logic [W_ADDR-1:0] LAST_REG = W_ADDR'(N_REGS - 1);
    localparam logic [W_ADDR:0]   N_REGS_A = (W_ADDR + 1)'(N_REGS);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [W_ADDR-1:0] clr_cnt;
    logic              dbg_issue;
    logic              dbg_addr_ok;
    logic              core_wen_ok;

    // x0 and out-of-range debug addresses never touch the array
    assign dbg_addr_ok = (bus.dbg_addr != '0) &&
                         ({1'b0, bus.dbg_addr} < N_REGS_A);

    assign core_wen_ok = bus.core_wen && (bus.core_waddr != '0);

    assign dbg_issue = (state == ST_RUN) && bus.dbg_req &&
                       bus.dbg_halted && !bus.core_wen;

    assign bus.core_ready = (state == ST_RUN) && !dbg_issue;
    assign bus.rf_raddr2  = bus.core_raddr2;

    always_comb begin
        state_nxt     = state;
        bus.rf_raddr1 = bus.core_raddr1;
        bus.rf_waddr  = bus.core_waddr;
        bus.rf_wdata  = bus.core_wdata;
        bus.rf_wen    = core_wen_ok;
        unique case (state)
            ST_CLEAR: begin
                bus.rf_waddr = clr_cnt;
                bus.rf_wdata = '0;
                bus.rf_wen   = 1'b1;
                if (clr_cnt == LAST_REG) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (dbg_issue && bus.dbg_write) begin
                    bus.rf_waddr = bus.dbg_addr;
                    bus.rf_wdata = bus.dbg_wdata;
                    bus.rf_wen   = dbg_addr_ok;
                    state_nxt    = ST_ACK;
                end else if (dbg_issue) begin
                    bus.rf_raddr1 = bus.dbg_addr;
                    state_nxt     = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: state_nxt = ST_ACK;
            ST_ACK:     state_nxt = ST_RUN;
            default:    state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RESET;
            clr_cnt       <= '0;
            bus.dbg_ack   <= 1'b0;
            bus.dbg_rdata <= '0;
        end else begin
            state       <= state_nxt;
            bus.dbg_ack <= (state_nxt == ST_ACK);
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + W_ADDR'(1);
            end
            // array read data arrives the cycle after the address was issued
            if (state == ST_RD_WAIT) begin
                bus.dbg_rdata <= dbg_addr_ok ? bus.rf_rdata1 : '0;
            end
        end
    end

endmodule
